// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
//   Fetch and pre-decode stage of the multicycle RV64I core. Holds the PC,
//   reads one instruction word per instruction over a req/ack handshake,
//   latches it into the instruction register and classifies its opcode into
//   the immediate-format select used by the immediate generator.
//
// Handshakes:
//   imem_req/imem_ack: imem_req is high for the whole FETCH state with
//     imem_addr = pc held stable; the word is taken on the first rising edge
//     with imem_req=1 and imem_ack=1. imem_ack while imem_req=0 is ignored.
//   inst_valid/advance: inst_valid=1 means inst/imm_sel/illegal/pc are
//     stable; the sequencer releases the instruction with advance=1 (and
//     optionally pc_load=1 to redirect). advance/pc_load are ignored while
//     inst_valid=0.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   imem_req       instruction memory read request
//   imem_addr      read address (equals pc)
//   imem_ack       read data returned this cycle
//   imem_rdata     32-bit instruction word
//   advance        fetch the next instruction
//   pc_load        with advance: redirect to pc_target (low two bits dropped)
//   pc_target      branch/jump target
//   pc             address of the held instruction
//   inst           held instruction, zero-extended to XLEN
//   imm_sel        immediate format: 0=I 1=S 2=SB 3=U 4=UJ
//   inst_valid     inst/imm_sel/illegal valid and stable
//   illegal        opcode outside the supported set
//   fsm_state      debug view of the FSM: 0=IDLE 1=FETCH 2=DECODE 3=HOLD
module fetch_decode_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            advance,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst,
  output logic [2:0]      imm_sel,
  output logic            inst_valid,
  output logic            illegal,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state;
  state_t          state_next;
  logic [2:0]      dec_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] target_aligned;

  // Target low bits are dropped by alignment; keep them visibly consumed.
  logic unused_target_bits;
  assign unused_target_bits = ^pc_target[1:0];

  assign target_aligned = {pc_target[XLEN-1:2], 2'b00};

  // Outputs are decoded from the state register, so they change only on
  // clock edges (req rises the cycle after IDLE, valid only in HOLD).
  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);
  assign fsm_state  = state;

  // Opcode classification of the held word. Full 7-bit compares also reject
  // compressed encodings (inst[1:0] != 2'b11).
  always_comb begin
    dec_sel     = IMM_I;
    dec_illegal = 1'b0;
    case (inst[6:0])
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011:              dec_sel = IMM_I;
      7'b0100011:                          dec_sel = IMM_S;
      7'b1100011:                          dec_sel = IMM_SB;
      7'b0110111, 7'b0010111:              dec_sel = IMM_U;
      7'b1101111:                          dec_sel = IMM_UJ;
      7'b0110011, 7'b0111011:              dec_sel = IMM_I;
      default:                             dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack) state_next = DECODE;
      DECODE:  state_next = HOLD;
      HOLD:    if (advance) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      inst    <= '0;
      imm_sel <= IMM_I;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: begin
          if (imem_ack) inst <= {{(XLEN-32){1'b0}}, imem_rdata};
        end
        DECODE: begin
          imm_sel <= dec_sel;
          illegal <= dec_illegal;
        end
        HOLD: begin
          // pc+4 wraps naturally at 2^XLEN.
          if (advance) pc <= pc_load ? target_aligned : pc + PC_STEP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit
//   Self-checking bench for fetch_decode_unit: directed scenarios plus a
//   randomized fetch/advance sequence checked against a reference model of
//   the PC sequence and the opcode classification table.
module tb_fetch_decode_unit;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0;

  logic            clk;
  logic            rst_n;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            advance;
  logic            pc_load;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;
  logic [2:0]      imm_sel;
  logic            inst_valid;
  logic            illegal;
  logic [1:0]      fsm_state;

  int checks;
  int failures;
  int cyc;

  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] exp_q[$];

  fetch_decode_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .advance    (advance),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .pc         (pc),
    .inst       (inst),
    .imm_sel    (imm_sel),
    .inst_valid (inst_valid),
    .illegal    (illegal),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim_time_exceeded got=running want=finished");
    $fatal(1, "watchdog");
  end

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    imem_ack = 1'b0;
    advance = 1'b0;
    pc_load = 1'b0;
    for (int i = 0; i < n; i++) step();
    exp_pc = RESET_PC;
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  // Immediate format and legality straight from the opcode table.
  task automatic ref_decode(input logic [31:0] w, output logic [2:0] sel,
                            output logic ill);
    logic [6:0] op;
    op  = w[6:0];
    sel = 3'd0;
    ill = 1'b0;
    if (op == 7'h03 || op == 7'h13 || op == 7'h1B || op == 7'h67 || op == 7'h73)
      sel = 3'd0;
    else if (op == 7'h23) sel = 3'd1;
    else if (op == 7'h63) sel = 3'd2;
    else if (op == 7'h37 || op == 7'h17) sel = 3'd3;
    else if (op == 7'h6F) sel = 3'd4;
    else if (op == 7'h33 || op == 7'h3B) sel = 3'd0;
    else ill = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Serve one fetch with wait_cyc wait states, then check the decoded result.
  // Entry: sampling point in or just before FETCH. Exit: sampling point in HOLD.
  task automatic do_fetch(input logic [31:0] w, input int wait_cyc, input string tag);
    int n;
    logic [2:0] e_sel;
    logic e_ill;
    logic [XLEN-1:0] old_inst;
    logic [XLEN-1:0] e_inst;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL %s req_timeout got=%b want=1", tag, imem_req);
      return;
    end
    checks++;
    if (imem_addr !== exp_pc) begin
      failures++;
      $display("FAIL %s fetch_addr got=%h want=%h", tag, imem_addr, exp_pc);
    end
    old_inst = inst;
    for (int i = 0; i < wait_cyc; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst !== old_inst) begin
        failures++;
        $display("FAIL %s wait_state%0d got req=%b addr=%h inst=%h want req=1 addr=%h inst=%h",
                 tag, i, imem_req, imem_addr, inst, exp_pc, old_inst);
      end
    end
    exp_q.push_back({32'b0, w});
    imem_rdata = w;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    checks++;
    if (imem_req !== 1'b0 || fsm_state !== 2'd2 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s after_ack got req=%b state=%0d valid=%b want req=0 state=2 valid=0",
               tag, imem_req, fsm_state, inst_valid);
    end
    checks++;
    if (inst !== exp_q[0]) begin
      failures++;
      $display("FAIL %s inst_at_ack got=%h want=%h", tag, inst, exp_q[0]);
    end
    step();
    ref_decode(w, e_sel, e_ill);
    e_inst = exp_q.pop_front();
    checks++;
    if (inst_valid !== 1'b1 || imm_sel !== e_sel || illegal !== e_ill ||
        inst !== e_inst || pc !== exp_pc) begin
      failures++;
      $display("FAIL %s decoded got valid=%b sel=%0d ill=%b inst=%h pc=%h want valid=1 sel=%0d ill=%b inst=%h pc=%h",
               tag, inst_valid, imm_sel, illegal, inst, pc, 1'b1, e_sel, e_ill, e_inst, exp_pc);
    end
  endtask

  // Pulse advance for one cycle from HOLD and check the redirected fetch.
  task automatic do_advance(input logic load, input logic [XLEN-1:0] tgt, input string tag);
    logic [XLEN-1:0] old_inst;
    old_inst = inst;
    advance = 1'b1;
    pc_load = load;
    pc_target = tgt;
    step();
    advance = 1'b0;
    pc_load = 1'b0;
    pc_target = {$urandom, $urandom};
    exp_pc = load ? {tgt[XLEN-1:2], 2'b00} : exp_pc + 64'd4;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc || inst_valid !== 1'b0 || inst !== old_inst) begin
      failures++;
      $display("FAIL %s advance got req=%b addr=%h valid=%b inst=%h want req=1 addr=%h valid=0 inst=%h",
               tag, imem_req, imem_addr, inst_valid, inst, exp_pc, old_inst);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hold_reset(3);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || pc !== RESET_PC || inst !== 64'h0 ||
        imm_sel !== 3'd0 || inst_valid !== 1'b0 || illegal !== 1'b0 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_values got req=%b addr=%h pc=%h inst=%h sel=%0d valid=%b ill=%b state=%0d want all reset",
               imem_req, imem_addr, pc, inst, imm_sel, inst_valid, illegal, fsm_state);
    end
  endtask

  task automatic test_first_fetch();
    rst_n = 1'b1;
    step();
    // Cycle 1 after release: request up at RESET_PC.
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    // Zero-wait ack: valid two edges later (cycle 3).
    do_fetch(32'h00500093, 0, "first_addi");
  endtask

  task automatic test_sequential();
    logic [31:0] words[4];
    words = '{32'h00112423, 32'h00208463, 32'h123450b7, 32'h008000ef};
    hold_reset(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) do_advance(1'b0, '0, "seq_adv");
      do_fetch(words[i], 0, "seq");
    end
  endtask

  task automatic test_branch();
    logic [XLEN-1:0] held_pc;
    held_pc = pc;
    // pc_load without advance: nothing moves.
    pc_load = 1'b1;
    pc_target = 64'h0000_0000_0000_0203;
    step();
    step();
    pc_load = 1'b0;
    checks++;
    if (fsm_state !== 2'd3 || pc !== held_pc || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL load_no_advance got state=%0d pc=%h valid=%b req=%b want state=3 pc=%h valid=1 req=0",
               fsm_state, pc, inst_valid, imem_req, held_pc);
    end
    do_advance(1'b1, 64'h103, "taken_branch");
    do_fetch(32'h00000013, 0, "branch_target");
  endtask

  task automatic test_wait_states();
    logic [XLEN-1:0] held_inst;
    held_inst = inst;
    // Spurious ack while no request is outstanding.
    imem_rdata = 32'hDEADBEEF;
    imem_ack = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    checks++;
    if (inst !== held_inst || fsm_state !== 2'd3 || inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL spurious_ack got inst=%h state=%0d valid=%b want inst=%h state=3 valid=1",
               inst, fsm_state, inst_valid, held_inst);
    end
    do_advance(1'b0, '0, "wait_adv");
    do_fetch(32'h0040a103, 5, "wait5");
  endtask

  task automatic test_illegal();
    do_advance(1'b0, '0, "ill_adv0");
    do_fetch(32'h0000007F, 1, "illegal_7f");
    do_advance(1'b0, '0, "ill_adv1");
    do_fetch(32'h00000010, 0, "illegal_compressed");
  endtask

  task automatic test_random();
    logic [6:0] ops[12];
    logic [31:0] r;
    logic [31:0] w;
    int k;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_advance(1'b1, {$urandom, $urandom}, "rnd_jump");
      else
        do_advance(1'b0, '0, "rnd_adv");
      r = $urandom;
      k = $urandom_range(0, 12);
      w = (k == 12) ? r : {r[31:7], ops[k]};
      do_fetch(w, $urandom_range(0, 3), "rnd");
    end
  endtask

  // advance held high, zero-wait memory: FETCH, DECODE, HOLD take one cycle
  // each, so request rises are 3 edges apart.
  task automatic test_back_to_back();
    int last_rise;
    logic [31:0] w;
    logic [2:0] e_sel;
    logic e_ill;
    last_rise = 0;
    advance = 1'b1;
    exp_pc = exp_pc + 64'd4;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || (i > 0 && cyc - last_rise != 3)) begin
        failures++;
        $display("FAIL b2b_req%0d got req=%b addr=%h gap=%0d want req=1 addr=%h gap=3",
                 i, imem_req, imem_addr, cyc - last_rise, exp_pc);
      end
      last_rise = cyc;
      w = $urandom;
      imem_rdata = w;
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      step();
      ref_decode(w, e_sel, e_ill);
      checks++;
      if (inst_valid !== 1'b1 || inst !== {32'b0, w} || imm_sel !== e_sel || illegal !== e_ill) begin
        failures++;
        $display("FAIL b2b_dec%0d got valid=%b inst=%h sel=%0d ill=%b want valid=1 inst=%h sel=%0d ill=%b",
                 i, inst_valid, inst, imm_sel, illegal, {32'b0, w}, e_sel, e_ill);
      end
      if (i == 5) advance = 1'b0;
      else exp_pc = exp_pc + 64'd4;
    end
    step();
    checks++;
    if (fsm_state !== 2'd3 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop got state=%0d req=%b want state=3 req=0", fsm_state, imem_req);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_advance(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "wrap_load");
    do_fetch(32'h00000013, 0, "wrap_top");
    do_advance(1'b0, '0, "wrap_adv");
    do_fetch(32'h00000013, 0, "wrap_zero");
    do_advance(1'b0, '0, "pre_reset_adv");
    // Mid-FETCH at pc=4 with no ack yet: reset, then a late ack.
    rst_n = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b0 || pc !== RESET_PC || imem_addr !== RESET_PC || inst !== 64'h0 ||
        imm_sel !== 3'd0 || illegal !== 1'b0 || inst_valid !== 1'b0 || fsm_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_fetch got req=%b pc=%h inst=%h sel=%0d ill=%b valid=%b state=%0d want reset values",
               imem_req, pc, inst, imm_sel, illegal, inst_valid, fsm_state);
    end
    imem_rdata = 32'h00c00513;
    imem_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++;
    if (fsm_state !== 2'd1 || inst !== 64'h0 || imem_addr !== RESET_PC || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL late_ack got state=%0d inst=%h addr=%h req=%b want state=1 inst=0 addr=%h req=1",
               fsm_state, inst, imem_addr, imem_req, RESET_PC);
    end
    exp_pc = RESET_PC;
    do_fetch(32'h00500093, 1, "refetch");
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    advance = 1'b0;
    pc_load = 1'b0;
    pc_target = '0;
    exp_pc = RESET_PC;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_wait_states();
    test_illegal();
    test_random();
    test_back_to_back();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
